// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use / dependency stalls, branch flushes,
// memory-wait freezes with a sticky timeout flag and a saturating stall counter.
module pipeline_hazard_controller #(
    parameter bit          FORWARD_EN  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           i_Src_1,
    input  logic [3:0]           i_Src_2,
    input  logic                 i_Two_Src,
    input  logic [3:0]           i_Exe_Dest,
    input  logic                 i_Exe_Wb_En,
    input  logic                 i_Exe_Mem_Read_En,
    input  logic [3:0]           i_Mem_Dest,
    input  logic                 i_Mem_Wb_En,
    input  logic                 i_Branch_Taken,
    input  logic                 i_Mem_Req,
    input  logic                 i_Mem_Ready,
    output logic                 o_Freeze_If,
    output logic                 o_Flush_If_Id,
    output logic                 o_Freeze_Id_Ex,
    output logic                 o_Flush_Id_Ex,
    output logic                 o_Freeze_Ex_Mem,
    output logic [1:0]           o_State,
    output logic [CNT_WIDTH-1:0] o_Stall_Count,
    output logic                 o_Mem_Timeout
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              exe_match;
    logic              mem_match;
    logic              hz;
    logic              mem_stall;
    logic              any_freeze;

    // Hazard detection; without forwarding any in-flight writeback is a hazard
    always_comb begin
        exe_match = (i_Src_1 == i_Exe_Dest) || (i_Two_Src && (i_Src_2 == i_Exe_Dest));
        mem_match = (i_Src_1 == i_Mem_Dest) || (i_Two_Src && (i_Src_2 == i_Mem_Dest));
        hz        = exe_match && i_Exe_Wb_En && (i_Exe_Mem_Read_En || !FORWARD_EN);
        if (!FORWARD_EN) begin
            hz = hz || (mem_match && i_Mem_Wb_En);
        end
        mem_stall = i_Mem_Req && !i_Mem_Ready;
    end

    // Same-cycle pipeline control: memory stall > branch > hazard
    always_comb begin
        o_Freeze_If     = 1'b0;
        o_Flush_If_Id   = 1'b0;
        o_Freeze_Id_Ex  = 1'b0;
        o_Flush_Id_Ex   = 1'b0;
        o_Freeze_Ex_Mem = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                o_Freeze_If     = 1'b1;
                o_Freeze_Id_Ex  = 1'b1;
                o_Freeze_Ex_Mem = 1'b1;
            end else if (i_Branch_Taken) begin
                o_Flush_If_Id = 1'b1;
                o_Flush_Id_Ex = 1'b1;
            end else if (hz) begin
                o_Freeze_If   = 1'b1;
                o_Flush_Id_Ex = 1'b1;
            end
        end
        any_freeze = o_Freeze_If || o_Freeze_Id_Ex || o_Freeze_Ex_Mem;
    end

    // Next state and memory-wait counter (saturates so the flag stays reachable)
    always_comb begin
        state_nxt = RUN;
        if (mem_stall) begin
            state_nxt = MEM_WAIT;
        end else if (hz && !i_Branch_Taken) begin
            state_nxt = LOAD_STALL;
        end

        wait_nxt = wait_cnt;
        if (mem_stall) begin
            if (state != MEM_WAIT) begin
                wait_nxt = '0;
            end else if (wait_cnt != '1) begin
                wait_nxt = wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            wait_cnt      <= '0;
            o_Stall_Count <= '0;
            o_Mem_Timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (mem_stall && (wait_nxt == WAIT_W'(MEM_TIMEOUT))) begin
                o_Mem_Timeout <= 1'b1;
            end
            if (any_freeze && (o_Stall_Count != '1)) begin
                o_Stall_Count <= o_Stall_Count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_State = state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: a forwarding instance (timeout 4) and a non-forwarding
// instance (3-bit stall counter) share stimulus and are checked side by side.
module tb_pipeline_hazard_controller;

    localparam int unsigned CNT_W_A = 16;
    localparam int unsigned CNT_W_B = 3;
    localparam int unsigned NV      = 16;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_MEM  = 5'b10101;
    localparam logic [4:0] C_BR   = 5'b01010;
    localparam logic [4:0] C_HZ   = 5'b10010;

    typedef struct {
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic [3:0] ed;
        logic       wb;
        logic       rd;
        logic [3:0] md;
        logic       mwb;
        logic       br;
        logic       req;
        logic       rdy;
        logic [4:0] exp_a;
        logic [1:0] st_a;
        logic [4:0] exp_b;
        logic [1:0] st_b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] src_1, src_2, exe_dest, mem_dest;
    logic       two_src, exe_wb_en, exe_rd_en, mem_wb_en, br_taken, mem_req, mem_ready;

    logic               a_fif, a_flid, a_fide, a_flide, a_fexm, a_to;
    logic [1:0]         a_state;
    logic [CNT_W_A-1:0] a_cnt;
    logic               b_fif, b_flid, b_fide, b_flide, b_fexm, b_to;
    logic [1:0]         b_state;
    logic [CNT_W_B-1:0] b_cnt;
    logic [4:0]         ctrl_a, ctrl_b;

    assign ctrl_a = {a_fif, a_flid, a_fide, a_flide, a_fexm};
    assign ctrl_b = {b_fif, b_flid, b_fide, b_flide, b_fexm};

    pipeline_hazard_controller #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_WIDTH(CNT_W_A)) dut_a (
        .clk(clk), .reset(reset),
        .i_Src_1(src_1), .i_Src_2(src_2), .i_Two_Src(two_src),
        .i_Exe_Dest(exe_dest), .i_Exe_Wb_En(exe_wb_en), .i_Exe_Mem_Read_En(exe_rd_en),
        .i_Mem_Dest(mem_dest), .i_Mem_Wb_En(mem_wb_en), .i_Branch_Taken(br_taken),
        .i_Mem_Req(mem_req), .i_Mem_Ready(mem_ready),
        .o_Freeze_If(a_fif), .o_Flush_If_Id(a_flid), .o_Freeze_Id_Ex(a_fide),
        .o_Flush_Id_Ex(a_flide), .o_Freeze_Ex_Mem(a_fexm), .o_State(a_state),
        .o_Stall_Count(a_cnt), .o_Mem_Timeout(a_to)
    );

    pipeline_hazard_controller #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(255), .CNT_WIDTH(CNT_W_B)) dut_b (
        .clk(clk), .reset(reset),
        .i_Src_1(src_1), .i_Src_2(src_2), .i_Two_Src(two_src),
        .i_Exe_Dest(exe_dest), .i_Exe_Wb_En(exe_wb_en), .i_Exe_Mem_Read_En(exe_rd_en),
        .i_Mem_Dest(mem_dest), .i_Mem_Wb_En(mem_wb_en), .i_Branch_Taken(br_taken),
        .i_Mem_Req(mem_req), .i_Mem_Ready(mem_ready),
        .o_Freeze_If(b_fif), .o_Flush_If_Id(b_flid), .o_Freeze_Id_Ex(b_fide),
        .o_Flush_Id_Ex(b_flide), .o_Freeze_Ex_Mem(b_fexm), .o_State(b_state),
        .o_Stall_Count(b_cnt), .o_Mem_Timeout(b_to)
    );

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                                input logic [3:0] ed, input logic wb, input logic rd,
                                input logic [3:0] md, input logic mwb, input logic br,
                                input logic req, input logic rdy,
                                input logic [4:0] ea, input logic [1:0] sa,
                                input logic [4:0] eb, input logic [1:0] sb);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.two = two; v.ed = ed; v.wb = wb; v.rd = rd;
        v.md = md; v.mwb = mwb; v.br = br; v.req = req; v.rdy = rdy;
        v.exp_a = ea; v.st_a = sa; v.exp_b = eb; v.st_b = sb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        src_1 = v.s1; src_2 = v.s2; two_src = v.two;
        exe_dest = v.ed; exe_wb_en = v.wb; exe_rd_en = v.rd;
        mem_dest = v.md; mem_wb_en = v.mwb; br_taken = v.br;
        mem_req = v.req; mem_ready = v.rdy;
    endtask

    task automatic set_idle();
        drive(mk(4'd1, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0,
                 C_NONE, 2'd0, C_NONE, 2'd0));
    endtask

    task automatic load_use();
        drive(mk(4'd5, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0,
                 C_HZ, 2'd1, C_HZ, 2'd1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle applied over a live memory stall
    task automatic reset_dut(input string tag);
        reset = 1'b1;
        mem_req = 1'b1;
        mem_ready = 1'b0;
        #3;
        check({tag, " rst ctrl_a"}, 32'(ctrl_a), 32'(C_NONE));
        check({tag, " rst ctrl_b"}, 32'(ctrl_b), 32'(C_NONE));
        step();
        check({tag, " rst state"}, 32'(a_state), 32'd0);
        check({tag, " rst count"}, 32'(a_cnt), 32'd0);
        check({tag, " rst timeout"}, 32'(a_to), 32'd0);
        check({tag, " rst count_b"}, 32'(b_cnt), 32'd0);
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(4'd1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, C_NONE, 2'd0);
        vecs[1]  = mk(4'd5, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_HZ,   2'd1, C_HZ,   2'd1);
        vecs[2]  = mk(4'd1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, C_HZ,   2'd1);
        vecs[3]  = mk(4'd1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, C_NONE, 2'd0);
        vecs[4]  = mk(4'd5, 4'd2, 1'b0, 4'd5, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, C_NONE, 2'd0);
        vecs[5]  = mk(4'd9, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, C_HZ,   2'd1);
        vecs[6]  = mk(4'd9, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, C_NONE, 2'd0);
        vecs[7]  = mk(4'd5, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,   2'd0, C_BR,   2'd0);
        vecs[8]  = mk(4'd5, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, C_MEM,  2'd2, C_MEM,  2'd2);
        vecs[9]  = mk(4'd5, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, C_HZ,   2'd1, C_HZ,   2'd1);
        vecs[10] = mk(4'd1, 4'd2, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 2'd0, C_NONE, 2'd0);
        vecs[11] = mk(4'd1, 4'd9, 1'b1, 4'd5, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, C_HZ,   2'd1);
        vecs[12] = mk(4'd1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_HZ,   2'd1, C_HZ,   2'd1);
        vecs[13] = mk(4'd1, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,   2'd0, C_BR,   2'd0);
        vecs[14] = mk(4'd1, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, C_MEM,  2'd2, C_MEM,  2'd2);
        vecs[15] = mk(4'd1, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 2'd0, C_NONE, 2'd0);

        reset = 1'b1;
        set_idle();
        reset_dut("init");

        // Table: same-cycle control and next state for both instances
        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i]);
            #3;
            check($sformatf("vec%0d ctrl_a", i), 32'(ctrl_a), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d ctrl_b", i), 32'(ctrl_b), 32'(vecs[i].exp_b));
            step();
            check($sformatf("vec%0d state_a", i), 32'(a_state), 32'(vecs[i].st_a));
            check($sformatf("vec%0d state_b", i), 32'(b_state), 32'(vecs[i].st_b));
        end

        // Load-use: one stall cycle, then back to RUN
        reset_dut("lu");
        load_use();
        step();
        check("lu state", 32'(a_state), 32'd1);
        check("lu count", 32'(a_cnt), 32'd1);
        set_idle();
        step();
        check("lu state back", 32'(a_state), 32'd0);
        check("lu count hold", 32'(a_cnt), 32'd1);

        // Memory wait: three stalled cycles then ready
        reset_dut("mw");
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            check($sformatf("mw%0d ctrl", k), 32'(ctrl_a), 32'(C_MEM));
            step();
            check($sformatf("mw%0d state", k), 32'(a_state), 32'd2);
        end
        mem_ready = 1'b1;
        #3;
        check("mw ready ctrl", 32'(ctrl_a), 32'(C_NONE));
        step();
        check("mw ready state", 32'(a_state), 32'd0);
        check("mw count", 32'(a_cnt), 32'd3);
        check("mw no timeout", 32'(a_to), 32'd0);

        // Branch held across a memory stall is honoured once the stall clears
        reset_dut("brm");
        load_use();
        br_taken = 1'b1;
        mem_req = 1'b1;
        mem_ready = 1'b0;
        #3;
        check("brm stall ctrl", 32'(ctrl_a), 32'(C_MEM));
        step();
        check("brm stall state", 32'(a_state), 32'd2);
        mem_ready = 1'b1;
        #3;
        check("brm flush ctrl", 32'(ctrl_a), 32'(C_BR));
        step();
        check("brm flush state", 32'(a_state), 32'd0);
        check("brm count", 32'(a_cnt), 32'd1);

        // Timeout after five stalled edges, sticky past ready, cleared by reset
        reset_dut("to");
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) check("to before", 32'(a_to), 32'd0);
            if (k == 5) check("to set", 32'(a_to), 32'd1);
        end
        #3;
        check("to freeze ctrl", 32'(ctrl_a), 32'(C_MEM));
        mem_ready = 1'b1;
        #1;
        check("to ready ctrl", 32'(ctrl_a), 32'(C_NONE));
        step();
        check("to sticky", 32'(a_to), 32'd1);
        check("to state", 32'(a_state), 32'd0);
        check("to count", 32'(a_cnt), 32'd5);
        mem_ready = 1'b0;
        step();
        check("to rewait state", 32'(a_state), 32'd2);
        reset_dut("to mid");
        #3;
        check("post rst ctrl", 32'(ctrl_a), 32'(C_NONE));
        step();
        check("post rst state", 32'(a_state), 32'd0);
        check("post rst count", 32'(a_cnt), 32'd0);

        // Stall counter saturation on the 3-bit instance
        reset_dut("sat");
        load_use();
        repeat (9) step();
        check("sat count_a", 32'(a_cnt), 32'd9);
        check("sat count_b", 32'(b_cnt), 32'd7);
        check("sat state_b", 32'(b_state), 32'd1);
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
